// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises rx_serial, frames start/data/stop bits using
// pulses from an external baud counter, and holds each byte on a valid/ready register.
module uart_rx_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_serial,
  input  logic                  baud_clock_half_cycle_edge,
  input  logic                  baud_clock_full_cycle_edge,
  input  logic                  all_bits_done,
  output logic                  reset_counters,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  framing_error,
  output logic                  overrun_error
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rx_s, rx_prev_q, start_det;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  deliver, frame_bad;
  logic                  unused_full_edge;

  // End-of-bit pulse is only of interest to debug/statistics logic outside this block.
  assign unused_full_edge = baud_clock_full_cycle_edge;

  assign rx_s           = sync_q[SYNC_STAGES-1];
  assign start_det      = rx_prev_q & ~rx_s;
  assign reset_counters = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_serial};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    unique case (state_q)
      IDLE: if (start_det) state_d = START;
      START: begin
        if (all_bits_done) begin
          state_d   = IDLE;
          frame_bad = 1'b1;
        end else if (baud_clock_half_cycle_edge) begin
          state_d = rx_s ? IDLE : DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (all_bits_done) begin
          state_d   = IDLE;
          frame_bad = 1'b1;
        end else if (baud_clock_half_cycle_edge) begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          idx_d   = idx_q + IDX_WIDTH'(1);
          if (idx_q == IDX_WIDTH'(DATA_WIDTH - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Timeout beats a coincident mid-bit sample; leaving mid-stop-bit re-arms for the next start.
        if (all_bits_done) begin
          state_d   = IDLE;
          frame_bad = 1'b1;
        end else if (baud_clock_half_cycle_edge) begin
          state_d   = IDLE;
          deliver   = rx_s;
          frame_bad = ~rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: the shift register holds exactly the data bits after the start bit, LSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun_error <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller with a behavioural baud counter and a
// frame-level reference model (byte order, framing and overrun counts).
module tb_uart_rx_controller;

  localparam int W    = 8;
  localparam int BAUD = 16;
  localparam int HALF = 6;
  localparam int FRAME_CYC = BAUD * (W + 2);

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_serial;
  logic         half_edge, full_edge, all_bits_done;
  logic         reset_counters;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         framing_error, overrun_error;

  uart_rx_controller #(.DATA_WIDTH(W), .SYNC_STAGES(2), .IDX_WIDTH(4)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .rx_serial                  (rx_serial),
    .baud_clock_half_cycle_edge (half_edge),
    .baud_clock_full_cycle_edge (full_edge),
    .all_bits_done              (all_bits_done),
    .reset_counters             (reset_counters),
    .rx_data                    (rx_data),
    .rx_valid                   (rx_valid),
    .rx_ready                   (rx_ready),
    .framing_error              (framing_error),
    .overrun_error              (overrun_error)
  );

  always #5 clk = ~clk;

  // Behavioural baud counter; inject_bit forces a timeout coincident with that bit's mid-point.
  int cnt = 0, bitcnt = 0, inject_bit = -1;
  always @(posedge clk) begin
    if (reset_counters) begin
      cnt    <= 0;
      bitcnt <= 0;
    end else if (cnt == BAUD - 1) begin
      cnt    <= 0;
      bitcnt <= bitcnt + 1;
    end else begin
      cnt <= cnt + 1;
    end
  end
  assign half_edge     = !reset_counters && (cnt == HALF);
  assign full_edge     = !reset_counters && (cnt == BAUD - 1);
  assign all_bits_done = !reset_counters &&
                         ((full_edge && bitcnt == W + 1) || (half_edge && bitcnt == inject_bit));

  int checks = 0, errors = 0;
  int obs_fe = 0, obs_oe = 0, exp_fe = 0, exp_oe = 0;
  logic [W-1:0] exp_q[$];
  bit           hold_full = 1'b0;
  logic [W-1:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and counts error-pulse cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (framing_error) obs_fe++;
      if (overrun_error) obs_oe++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", rx_data, $time);
        end else begin
          check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame on the line; abort_at >= 0 stops driving at that cycle offset.
  task automatic send_frame(input logic [W-1:0] d, input bit stop, input int gap, input int abort_at);
    logic [W+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < FRAME_CYC + gap; c++) begin
      if (abort_at >= 0 && c == abort_at) return;
      rx_serial = (c < FRAME_CYC) ? bits[c / BAUD] : 1'b1;
      cycles(1);
    end
  endtask

  // Reference model at frame granularity: what the receiver should report for this frame.
  task automatic run_frame(input logic [W-1:0] d, input bit stop, input bit r, input int gap,
                           input int inject);
    rx_ready   = r;
    if (r) hold_full = 1'b0;
    inject_bit = inject;
    if (inject >= 0 || !stop) exp_fe++;
    else if (hold_full) exp_oe++;
    else begin
      exp_q.push_back(d);
      last_data = d;
      hold_full = !r;
    end
    send_frame(d, stop, gap, -1);
    inject_bit = -1;
  endtask

  task automatic phase_end(input string name);
    cycles(40);
    check({name, "_framing_cnt"}, obs_fe, exp_fe);
    check({name, "_overrun_cnt"}, obs_oe, exp_oe);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_serial = 1'b1; rx_ready = 1'b1;
    cycles(3);
    check("rst_reset_counters", reset_counters, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_framing", framing_error, 0);
    check("rst_overrun", overrun_error, 0);
    reset = 1'b0;
    cycles(5);

    run_frame(8'hA5, 1'b1, 1'b1, 20, -1);
    phase_end("frame_a5");

    rx_serial = 1'b0;
    cycles(4);
    rx_serial = 1'b1;
    cycles(2);
    check("glitch_in_start", reset_counters, 0);
    cycles(20);
    check("glitch_rearmed", reset_counters, 1);
    check("glitch_valid", rx_valid, 0);
    phase_end("glitch");

    run_frame(8'h3C, 1'b0, 1'b1, 20, -1);
    phase_end("bad_stop");
    check("bad_stop_data_kept", rx_data, last_data);
    check("bad_stop_valid", rx_valid, 0);

    run_frame(8'h11, 1'b1, 1'b0, 20, -1);
    run_frame(8'h22, 1'b1, 1'b0, 20, -1);
    cycles(10);
    check("overrun_valid_held", rx_valid, 1);
    check("overrun_data_held", rx_data, 8'h11);
    check("overrun_cnt", obs_oe, exp_oe);
    rx_ready = 1'b1;
    hold_full = 1'b0;
    cycles(2);
    check("consume_clears_valid", rx_valid, 0);
    phase_end("overrun");

    run_frame(8'h55, 1'b1, 1'b1, 0, -1);
    run_frame(8'hAA, 1'b1, 1'b1, 20, -1);
    phase_end("back_to_back");

    run_frame(8'hF3, 1'b1, 1'b1, 20, 5);
    run_frame(8'h5A, 1'b1, 1'b1, 20, 9);
    phase_end("timeout");
    check("timeout_data_kept", rx_data, last_data);

    run_frame(8'h66, 1'b1, 1'b0, 20, -1);
    send_frame(8'h99, 1'b1, 0, BAUD * 5 + BAUD / 2);
    #3;
    reset = 1'b1;
    #1;
    check("midframe_rst_counters", reset_counters, 1);
    check("midframe_rst_valid", rx_valid, 0);
    check("midframe_rst_data", rx_data, 0);
    exp_q.delete();
    hold_full = 1'b0;
    rx_serial = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(5);
    run_frame(8'h81, 1'b1, 1'b1, 20, -1);
    phase_end("after_reset");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] d;
      bit stop, r;
      int gap;
      d    = W'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      r    = 1'($urandom_range(0, 1));
      gap  = stop ? int'($urandom_range(0, 24)) : int'($urandom_range(16, 32));
      run_frame(d, stop, r, gap, -1);
    end
    rx_ready = 1'b1;
    hold_full = 1'b0;
    phase_end("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
